// File: rtl/e_mdu_seq_div.sv
// Iterative restoring divider (div/divu) feeding the MDU HI/LO write; WIDTH+1 cycle latency.
// Optional E_MDU_DIV_EARLY_OUT_EN: finish in 2 cycles when |dividend| < |divisor|.
module e_mdu_seq_div #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_done;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_early;

    always_comb begin
        w_a_neg = i_is_signed & i_dividend[WIDTH-1];
        w_b_neg = i_is_signed & i_divisor[WIDTH-1];
        // The most negative value maps onto itself, which is its correct unsigned magnitude.
        w_a_mag = w_a_neg ? -i_dividend : i_dividend;
        w_b_mag = w_b_neg ? -i_divisor : i_divisor;
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_dvs};
`ifdef E_MDU_DIV_EARLY_OUT_EN
        w_early = (i_divisor != '0) && (w_a_mag < w_b_mag);
`else
        w_early = 1'b0;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_nxt = w_early ? StFix : StCalc;
            StCalc:  if (r_cnt == CNT_W'(1)) w_state_nxt = StFix;
            StFix:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (i_abort) w_state_nxt = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start && !i_abort) begin
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dvs   <= w_b_mag;
                        r_cnt   <= CNT_W'(WIDTH);
                        if (w_early) begin
                            r_rem <= w_a_mag;
                            r_quo <= '0;
                        end else begin
                            r_rem <= '0;
                            r_quo <= w_a_mag;
                        end
                    end
                end
                StCalc: begin
                    if (!i_abort) begin
                        // Sign bit of the WIDTH+1-bit trial difference selects restore vs keep.
                        if (w_diff[WIDTH]) begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end else begin
                            r_rem <= w_diff[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StFix: begin
                    if (!i_abort) begin
                        r_quotient  <= r_neg_q ? -r_quo : r_quo;
                        r_remainder <= r_neg_r ? -r_rem : r_rem;
                        r_done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;

endmodule

// File: tb/tb_e_mdu_seq_div.sv
// Self-checking bench for e_mdu_seq_div: directed corner cases plus randomized
// operands against an arithmetic reference model.
module tb_e_mdu_seq_div;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic        i_abort;
    logic        i_is_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    int checks   = 0;
    int failures = 0;

    e_mdu_seq_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_is_signed (i_is_signed),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // C-style truncating division with the MIPS divide-by-zero and overflow results.
    function automatic void ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = (!sg || sa >= 0) ? 32'hFFFF_FFFF : 32'd1;
            r = a;
        end else if (!sg) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    function automatic int exp_latency(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
`ifdef E_MDU_DIV_EARLY_OUT_EN
        if (b != 32'd0 && ma < mb) return 1;
`endif
        if (ma == mb) return 33;
        return 33;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    // Launches one op and returns in the done cycle, so back-to-back calls start on done.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int          cyc;
        int          bcnt;
        int          lat;
        ref_div(sg, a, b, eq, er);
        lat         = exp_latency(sg, a, b);
        i_is_signed = sg;
        i_dividend  = a;
        i_divisor   = b;
        i_start     = 1'b1;
        step();
        i_start     = 1'b0;
        i_dividend  = $urandom;
        i_divisor   = $urandom;
        i_is_signed = 1'($urandom_range(0, 1));
        cyc  = 0;
        bcnt = 0;
        while (o_done !== 1'b1 && cyc < 100) begin
            if (o_busy === 1'b1) bcnt++;
            step();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'(lat));
        check({tag, "_busy_at_done"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_quotient"}, o_quotient, eq);
        check({tag, "_remainder"}, o_remainder, er);
    endtask

    initial begin
        int          cyc;
        logic        seen_done;
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;

        reset       = 1'b1;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_is_signed = 1'b0;
        i_dividend  = '0;
        i_divisor   = '0;
        step();
        step();
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        check("reset_done", {31'd0, o_done}, 32'd0);
        check("reset_quotient", o_quotient, 32'd0);
        check("reset_remainder", o_remainder, 32'd0);
        reset = 1'b0;
        step();

        run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        step();
        check("done_one_cycle", {31'd0, o_done}, 32'd0);
        check("hold_quotient", o_quotient, 32'd14);
        check("hold_remainder", o_remainder, 32'd2);

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_div(1'b0, 32'd5, 32'd0, "divu_by_zero");
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, "div_neg_by_zero");

        // Abort mid-flight keeps the previous result.
        run_div(1'b0, 32'd100, 32'd7, "pre_abort");
        step();
        i_is_signed = 1'b0;
        i_dividend  = 32'd9;
        i_divisor   = 32'd3;
        i_start     = 1'b1;
        step();
        i_start = 1'b0;
        repeat (9) step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_done", {31'd0, o_done}, 32'd0);
        check("abort_quotient", o_quotient, 32'd14);
        check("abort_remainder", o_remainder, 32'd2);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_done === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        run_div(1'b0, 32'd9, 32'd3, "after_abort");

        // Start while busy is ignored.
        step();
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        repeat (4) step();
        i_dividend = 32'd50;
        i_divisor  = 32'd5;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        wait_done(cyc);
        check("busy_start_latency", 32'(cyc), 32'd28);
        check("busy_start_quotient", o_quotient, 32'd14);
        check("busy_start_remainder", o_remainder, 32'd2);
        run_div(1'b0, 32'd50, 32'd5, "back_to_back");

        // start and abort together in idle launch nothing.
        step();
        i_start = 1'b1;
        i_abort = 1'b1;
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        check("start_abort_busy", {31'd0, o_busy}, 32'd0);
        step();
        check("start_abort_busy2", {31'd0, o_busy}, 32'd0);
        check("start_abort_done", {31'd0, o_done}, 32'd0);

        // Reset mid-operation clears outputs.
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        repeat (19) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_busy", {31'd0, o_busy}, 32'd0);
        check("midreset_done", {31'd0, o_done}, 32'd0);
        check("midreset_quotient", o_quotient, 32'd0);
        check("midreset_remainder", o_remainder, 32'd0);
        step();

        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = 32'd0;
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4:       b = -32'($urandom_range(1, 100));
                default: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 100)); end
            endcase
            run_div(sg, a, b, $sformatf("rand%0d", i));
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
